// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl
// Brief    : Framed UART command parser issuing register reads/writes and
//            returning ACK/NAK/read data; optional checksum via
//            UART_CMD_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
  parameter int          ADDR_W      = 8,
  parameter int          TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_data_valid,
  output logic              o_tx_en,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_buffer_full,
  output logic              o_reg_wr,
  output logic              o_reg_rd,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [7:0]        o_reg_wdata,
  input  logic [7:0]        i_reg_rdata,
  output logic              o_busy,
  output logic              o_err_timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] c_CMD_WR = 8'h01;
  localparam logic [7:0] c_CMD_RD = 8'h02;
  localparam logic [7:0] c_ACK    = 8'h5A;
  localparam logic [7:0] c_NAK    = 8'hEE;

  localparam logic [3:0] c_ST_IDLE   = 4'd0;
  localparam logic [3:0] c_ST_CMD    = 4'd1;
  localparam logic [3:0] c_ST_ADDR   = 4'd2;
  localparam logic [3:0] c_ST_DATA   = 4'd3;
  localparam logic [3:0] c_ST_EXEC   = 4'd4;
  localparam logic [3:0] c_ST_RDWAIT = 4'd5;
  localparam logic [3:0] c_ST_ACK    = 4'd6;
  localparam logic [3:0] c_ST_TXD    = 4'd7;
  localparam logic [3:0] c_ST_NAK    = 4'd8;
`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [3:0] c_ST_CSUM   = 4'd9;
`endif

  logic [3:0]        r_state;
  logic              r_is_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic [7:0]        r_rdata;
  logic [CNT_W-1:0]  r_cnt;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic       w_in_frame;
  logic       w_timeout;
  logic [3:0] w_after_payload;

  always_comb begin
    w_in_frame = (r_state == c_ST_CMD) || (r_state == c_ST_ADDR) ||
                 (r_state == c_ST_DATA)
`ifdef UART_CMD_CHECKSUM_EN
                 || (r_state == c_ST_CSUM)
`endif
                 ;
    w_timeout = w_in_frame && (r_cnt == c_TO_LAST);
`ifdef UART_CMD_CHECKSUM_EN
    w_after_payload = c_ST_CSUM;
`else
    w_after_payload = c_ST_EXEC;
`endif
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= c_ST_IDLE;
      r_is_rd <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      if (w_in_frame && !w_timeout && !i_rx_data_valid)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;

      case (r_state)
        c_ST_IDLE: begin
          if (i_rx_data_valid && (i_rx_data == HDR_BYTE))
            r_state <= c_ST_CMD;
        end
        c_ST_CMD: begin
          if (w_timeout) begin
            r_state <= c_ST_IDLE;
          end else if (i_rx_data_valid) begin
            if ((i_rx_data == c_CMD_WR) || (i_rx_data == c_CMD_RD)) begin
              r_is_rd <= (i_rx_data == c_CMD_RD);
              r_state <= c_ST_ADDR;
`ifdef UART_CMD_CHECKSUM_EN
              r_csum  <= i_rx_data;
`endif
            end else begin
              r_state <= c_ST_NAK;
            end
          end
        end
        c_ST_ADDR: begin
          if (w_timeout) begin
            r_state <= c_ST_IDLE;
          end else if (i_rx_data_valid) begin
            r_addr  <= ADDR_W'(i_rx_data);
            r_state <= r_is_rd ? w_after_payload : c_ST_DATA;
`ifdef UART_CMD_CHECKSUM_EN
            r_csum  <= r_csum ^ i_rx_data;
`endif
          end
        end
        c_ST_DATA: begin
          if (w_timeout) begin
            r_state <= c_ST_IDLE;
          end else if (i_rx_data_valid) begin
            r_wdata <= i_rx_data;
            r_state <= w_after_payload;
`ifdef UART_CMD_CHECKSUM_EN
            r_csum  <= r_csum ^ i_rx_data;
`endif
          end
        end
`ifdef UART_CMD_CHECKSUM_EN
        c_ST_CSUM: begin
          if (w_timeout)
            r_state <= c_ST_IDLE;
          else if (i_rx_data_valid)
            r_state <= (i_rx_data == r_csum) ? c_ST_EXEC : c_ST_NAK;
        end
`endif
        c_ST_EXEC:   r_state <= r_is_rd ? c_ST_RDWAIT : c_ST_ACK;
        c_ST_RDWAIT: begin
          r_rdata <= i_reg_rdata;
          r_state <= c_ST_ACK;
        end
        c_ST_ACK: begin
          if (!i_tx_buffer_full)
            r_state <= r_is_rd ? c_ST_TXD : c_ST_IDLE;
        end
        c_ST_TXD, c_ST_NAK: begin
          if (!i_tx_buffer_full)
            r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Strobes are gated by reset so a pending response or register access is
  // suppressed in the very cycle reset is asserted.
  always_comb begin
    o_tx_en       = 1'b0;
    o_tx_data     = 8'h00;
    case (r_state)
      c_ST_ACK: o_tx_data = c_ACK;
      c_ST_TXD: o_tx_data = r_rdata;
      c_ST_NAK: o_tx_data = c_NAK;
      default:  o_tx_data = 8'h00;
    endcase
    if ((r_state == c_ST_ACK) || (r_state == c_ST_TXD) || (r_state == c_ST_NAK))
      o_tx_en = !i_tx_buffer_full && !i_rst;
    o_reg_wr      = (r_state == c_ST_EXEC) && !r_is_rd && !i_rst;
    o_reg_rd      = (r_state == c_ST_EXEC) &&  r_is_rd && !i_rst;
    o_reg_addr    = r_addr;
    o_reg_wdata   = r_wdata;
    o_busy        = (r_state != c_ST_IDLE);
    o_err_timeout = w_timeout && !i_rst;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Byte-level command controller between the UART receive/transmit datapath and an internal register bus.
- Parses framed host commands from received bytes and issues single-beat register reads and writes.
- Returns ACK/NAK and read data through the UART transmit path, honouring transmit buffer backpressure.
- Lets the host PC configure and inspect the design over the serial link.

Parameters:
- ADDR_W, 8, register address width; address byte zero-extended or truncated to ADDR_W.
- TIMEOUT_CYC, 1000000, max clk cycles allowed between bytes of one frame before abort.
- HDR_BYTE, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_rx_data  in  8  received byte from UART
- i_rx_data_valid  in  1  one-cycle strobe: i_rx_data valid
- o_tx_en  out  1  one-cycle write strobe into UART tx buffer
- o_tx_data  out  8  byte to transmit, valid with o_tx_en
- i_tx_buffer_full  in  1  tx buffer cannot accept a write
- o_reg_wr  out  1  one-cycle register write strobe
- o_reg_rd  out  1  one-cycle register read strobe
- o_reg_addr  out  ADDR_W  register address
- o_reg_wdata  out  8  register write data
- i_reg_rdata  in  8  read data, valid exactly 1 cycle after o_reg_rd
- o_busy  out  1  high in every state except IDLE
- o_err_timeout  out  1  one-cycle pulse on inter-byte timeout abort

Behaviour:
- Frame: HDR_BYTE, CMD (8'h01 write, 8'h02 read), ADDR, DATA (write only).
- Responses:
  - write OK: 8'h5A;
  - read OK: 8'h5A then the read byte;
  - bad CMD: 8'hEE.
- Reset: state IDLE; all strobes 0; o_tx_data, o_reg_addr, o_reg_wdata = 0; timeout counter 0; o_busy 0.
- States and transitions:
  - IDLE: byte == HDR_BYTE -> CMD; any other byte is ignored.
  - CMD: 01 or 02 latched -> ADDR; any other value -> NAK.
  - ADDR: latch addr; write -> DATA; read -> EXEC.
  - DATA: latch wdata -> EXEC.
  - EXEC, write: o_reg_wr pulses 1 cycle -> ACK.
  - EXEC, read: o_reg_rd pulses 1 cycle -> RDWAIT.
  - RDWAIT: capture i_reg_rdata into a data register next cycle -> ACK.
  - ACK: wait for i_tx_buffer_full == 0, then pulse o_tx_en with 8'h5A. Write -> IDLE; read -> TXD.
  - TXD: wait for not full, then pulse o_tx_en with the captured read byte -> IDLE.
  - NAK: wait for not full, then pulse o_tx_en with 8'hEE -> IDLE.
- Transmit handshake: o_tx_en is asserted only in a cycle where i_tx_buffer_full is 0 (sampled same cycle). Exactly one strobe per response byte, never back-to-back duplicates.
- Latency: last frame byte to register strobe is 1 cycle. Write strobe to ACK o_tx_en is 1 cycle minimum (not full).
- Timeout:
  - Counter clears on every accepted byte and in IDLE. It increments in CMD, ADDR, DATA, CSUM.
  - On reaching TIMEOUT_CYC-1 the block returns to IDLE, pulses o_err_timeout, and sends no response.
- Bytes received in EXEC, RDWAIT, ACK, TXD, NAK are dropped. No queuing.
- A byte valid in the same cycle as the timeout is dropped; timeout wins.
- HDR_BYTE received mid-frame is treated as data, not as a resync.
- Reset mid-frame or mid-response: immediate IDLE. A pending response byte is not sent; a pending register strobe is not issued.

Optional Feature:
- Macro: UART_CMD_CHECKSUM_EN.
- Defined:
  - An extra CSUM state follows ADDR (read) or DATA (write).
  - Expected CSUM = XOR of CMD, ADDR, DATA (DATA omitted for read).
  - Match -> EXEC. Mismatch -> NAK (8'hEE) with no register strobe.
  - CSUM participates in timeout.
- Undefined: no CSUM state; frames are 3 (read) or 4 (write) bytes.

Test Plan:
- Write frame A5 01 10 3C, tx not full -> one o_reg_wr with addr 0x10, wdata 0x3C; then one o_tx_en with 0x5A; o_busy low after.
- Read frame A5 02 22, i_reg_rdata = 0x99 one cycle after o_reg_rd -> o_tx_en 0x5A then o_tx_en 0x99, no o_reg_wr.
- Read frame with i_tx_buffer_full held high 50 cycles -> no o_tx_en while full; then exactly 0x5A, 0x99 once each after release.
- Bytes 00 FF A5 07 -> the first two are ignored; NAK 0xEE sent; no register strobes.
- A5 01 then silence for TIMEOUT_CYC cycles (set to 16) -> o_err_timeout single pulse; IDLE; no tx. Following full write frame processed normally.
- With UART_CMD_CHECKSUM_EN: A5 01 10 3C 2D -> write + ACK. A5 01 10 3C 00 -> NAK 0xEE, no o_reg_wr. Separately, i_rst asserted during ACK wait -> no o_tx_en and state IDLE.
